// File: rtl/rr_arb_mux.sv
// Round-robin arbiter feeding one registered en/data/src output slot.
// Define ARB_HOLD_EN to let a winner keep the grant for up to MAX_HOLD consecutive beats.
module rr_arb_mux #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 4,
    parameter int SRC_W    = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_en,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src,
    input  logic                      out_ready
);

    logic [SRC_W-1:0]  r_ptr;
    logic [SRC_W-1:0]  w_win;
    logic [SRC_W-1:0]  w_win_inc;
    logic [SRC_W-1:0]  w_ptr_nxt;
    logic [DATA_W-1:0] w_win_data;
    logic              w_found;
    logic              w_load;
    logic              w_xfer;
    int                w_idx;

    // Wrap-around priority search starting at r_ptr.
    always_comb begin
        w_found    = 1'b0;
        w_win      = '0;
        w_win_data = '0;
        w_idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ)
                w_idx = w_idx - NUM_REQ;
            if (!w_found && req_valid[w_idx]) begin
                w_found    = 1'b1;
                w_win      = SRC_W'(w_idx);
                w_win_data = req_data[w_idx*DATA_W +: DATA_W];
            end
        end
    end

    // Slot takes a word when empty or draining this cycle; nobody is readied in reset.
    assign w_load    = !out_en || out_ready;
    assign w_xfer    = rst && w_found && w_load;
    assign w_win_inc = (w_win == SRC_W'(NUM_REQ-1)) ? '0 : w_win + SRC_W'(1);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++)
            req_ready[i] = w_xfer && (w_win == SRC_W'(i));
    end

`ifdef ARB_HOLD_EN
    logic [3:0] r_hold;
    logic [3:0] w_hold_nxt;

    // A beat continues the current run only if it repeats the last source and the run is not yet full.
    always_comb begin
        if (w_win == out_src && r_hold != 4'd0 && r_hold < 4'(MAX_HOLD))
            w_hold_nxt = r_hold + 4'd1;
        else
            w_hold_nxt = 4'd1;
        w_ptr_nxt = (w_hold_nxt >= 4'(MAX_HOLD)) ? w_win_inc : w_win;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_hold <= 4'd0;
        else if (w_xfer)
            r_hold <= w_hold_nxt;
    end
`else
    assign w_ptr_nxt = w_win_inc;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_en   <= 1'b0;
            out_data <= '0;
            out_src  <= '0;
            r_ptr    <= '0;
        end else if (w_xfer) begin
            out_en   <= 1'b1;
            out_data <= w_win_data;
            out_src  <= w_win;
            r_ptr    <= w_ptr_nxt;
        end else if (w_load) begin
            out_en   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux: expected {src,data} pushed at transfer, popped on accepted output beats.
module tb_rr_arb_mux;
    localparam int NUM_REQ  = 4;
    localparam int DATA_W   = 4;
    localparam int SRC_W    = 2;
    localparam int MAX_HOLD = 4;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_en;
    logic [DATA_W-1:0]         out_data;
    logic [SRC_W-1:0]          out_src;
    logic                      out_ready;

    logic [SRC_W+DATA_W-1:0]   sb_q[$];
    int                        checks;
    int                        errors;

    rr_arb_mux #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .SRC_W    (SRC_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_en    (out_en),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [SRC_W+DATA_W-1:0] ent(input int s, input int d);
        return {SRC_W'(s), DATA_W'(d)};
    endfunction

    // Advance one clock; an accepted output beat is popped from the scoreboard.
    task automatic cycle();
        logic [SRC_W+DATA_W-1:0] e;
        #1;
        if (out_en && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got src=%0d data=%h, no beat expected", out_src, out_data);
            end else begin
                e = sb_q.pop_front();
                if ({out_src, out_data} !== e) begin
                    errors++;
                    $display("FAIL sb_beat got src=%0d data=%h, expected src=%0d data=%h",
                             out_src, out_data, e[SRC_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        req_valid = 4'b1111;
        req_data  = {4'hD, 4'hC, 4'hB, 4'hA};
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (out_en !== 1'b0) begin errors++; $display("FAIL rst_en got %b expected 0", out_en); end
        if (out_data !== 4'h0) begin errors++; $display("FAIL rst_data got %h expected 0", out_data); end
        if (out_src !== 2'd0) begin errors++; $display("FAIL rst_src got %0d expected 0", out_src); end
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b expected 0000", req_ready); end
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL rel_ready got %b expected 0001", req_ready); end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_en, out_src, out_data} !== {1'b1, 2'd0, 4'hA})
            begin errors++; $display("FAIL first_beat got en=%b src=%0d data=%h expected 1 0 a", out_en, out_src, out_data); end
        // Asynchronous reset in mid-stream must clear the slot without a clock edge.
        #2 rst = 1'b0;
        #1;
        checks++;
        if (out_en !== 1'b0) begin errors++; $display("FAIL async_rst got en=%b expected 0", out_en); end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_rotation();
        do_reset();
        req_data  = {4'hD, 4'hC, 4'hB, 4'hA};
        req_valid = 4'b1111;
`ifdef ARB_HOLD_EN
        for (int k = 0; k < 5; k++) sb_q.push_back(ent(k / 4, 4'hA + k / 4));
`else
        for (int k = 0; k < 5; k++) sb_q.push_back(ent(k % 4, 4'hA + k % 4));
`endif
        for (int k = 0; k < 5; k++) begin
            cycle();
            checks++;
            if (out_en !== 1'b1) begin errors++; $display("FAIL rot_en cycle %0d got %b expected 1", k, out_en); end
        end
        req_valid = '0;
        cycle();
        checks += 2;
        if (out_en !== 1'b0) begin errors++; $display("FAIL rot_drain got en=%b expected 0", out_en); end
        if (sb_q.size() != 0) begin errors++; $display("FAIL rot_left got %0d expected 0", sb_q.size()); end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_data  = '0;
        req_data[2*DATA_W +: DATA_W] = 4'h5;
        req_valid = 4'b0100;
        out_ready = 1'b1;
        sb_q.push_back(ent(2, 4'h5));
        cycle();
        out_ready = 1'b0;
        req_data[2*DATA_W +: DATA_W] = 4'h6;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready got %b expected 0000", req_ready); end
            cycle();
            checks++;
            if ({out_en, out_src, out_data} !== {1'b1, 2'd2, 4'h5})
                begin errors++; $display("FAIL bp_hold got en=%b src=%0d data=%h expected 1 2 5", out_en, out_src, out_data); end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release got %b expected 0100", req_ready); end
        sb_q.push_back(ent(2, 4'h6));
        cycle();
        checks++;
        if ({out_en, out_data} !== {1'b1, 4'h6}) begin errors++; $display("FAIL bp_nobubble got en=%b data=%h expected 1 6", out_en, out_data); end
        req_valid = '0;
        cycle();
        checks += 2;
        if (out_en !== 1'b0) begin errors++; $display("FAIL bp_drain got en=%b expected 0", out_en); end
        if (sb_q.size() != 0) begin errors++; $display("FAIL bp_left got %0d expected 0", sb_q.size()); end
    endtask

    task automatic test_wraparound();
        logic [NUM_REQ-1:0] vals [7];
        int                 wins [7];
        vals = '{4'b0100, 4'b0011, 4'b0010, 4'b1001, 4'b0001, 4'b0100, 4'b1001};
        wins = '{2, 0, 1, 3, 0, 2, 3};
        do_reset();
        req_data = {4'h7, 4'h6, 4'h5, 4'h4};
        for (int k = 0; k < 7; k++) begin
            req_valid = vals[k];
            #1;
            checks++;
            if (req_ready !== 4'(1 << wins[k]))
                begin errors++; $display("FAIL wrap_ready step %0d got %b expected winner %0d", k, req_ready, wins[k]); end
            sb_q.push_back(ent(wins[k], 4 + wins[k]));
            cycle();
        end
        req_valid = '0;
        cycle();
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL wrap_left got %0d expected 0", sb_q.size()); end
    endtask

    task automatic test_idle();
        do_reset();
        req_data = '0;
        req_data[1*DATA_W +: DATA_W] = 4'h7;
        req_valid = 4'b0010;
        sb_q.push_back(ent(1, 4'h7));
        cycle();
        req_valid = '0;
        checks++;
        if (out_en !== 1'b1) begin errors++; $display("FAIL idle_pulse got en=%b expected 1", out_en); end
        for (int k = 0; k < 2; k++) begin
            cycle();
            checks++;
            if ({out_en, out_src, out_data} !== {1'b0, 2'd1, 4'h7})
                begin errors++; $display("FAIL idle_keep got en=%b src=%0d data=%h expected 0 1 7", out_en, out_src, out_data); end
        end
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL idle_left got %0d expected 0", sb_q.size()); end
    endtask

    task automatic test_hold();
        do_reset();
        req_data  = {4'h0, 4'h0, 4'h2, 4'h1};
        req_valid = 4'b0011;
`ifdef ARB_HOLD_EN
        for (int k = 0; k < 10; k++) sb_q.push_back(ent((k / MAX_HOLD) % 2, 1 + (k / MAX_HOLD) % 2));
`else
        for (int k = 0; k < 10; k++) sb_q.push_back(ent(k % 2, 1 + k % 2));
`endif
        repeat (10) cycle();
        req_valid = '0;
        cycle();
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL hold_left got %0d expected 0", sb_q.size()); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b1;
        test_reset();
        test_rotation();
        test_backpressure();
        test_wraparound();
        test_idle();
        test_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
